// File: rtl/carfield_pkg.sv
// Shared types for the Carfield domain power/clock/reset sequencer.
package carfield_pkg;

  typedef enum logic [2:0] {
    IDLE, CLK_ON, RST_REL, ISO_REL, ISO_SET, WAIT_IDLE, RST_SET, CLK_OFF
  } dom_seq_state_e;

  typedef struct packed {
    logic clk_en;
    logic rst;
    logic iso;
  } dom_ctrl_t;

  function automatic dom_ctrl_t dom_ctrl_reset(input logic boot_on);
    dom_ctrl_t c;
    if (boot_on) begin
      c.clk_en = 1'b1; c.rst = 1'b0; c.iso = 1'b0;
    end else begin
      c.clk_en = 1'b0; c.rst = 1'b1; c.iso = 1'b1;
    end
    return c;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/carfield_domain_seq_arb.sv
// Round-robin picker over pending domains; pointer advances past each grant.
module carfield_domain_seq_arb #(
  parameter int NumIn = 6,
  parameter int IdxW  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumIn-1:0] req_i,
  input  logic             en_i,
  output logic             gnt_valid_o,
  output logic [IdxW-1:0]  gnt_idx_o
);

  logic [IdxW-1:0] ptr_q;
  int              idx;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    idx         = 0;
    // Walk from the farthest slot back to ptr so the closest requester wins.
    for (int i = NumIn - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NumIn;
      if (req_i[idx]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(idx);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (en_i && gnt_valid_o) begin
      ptr_q <= (gnt_idx_o == IdxW'(NumIn - 1)) ? '0 : gnt_idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/carfield_domain_seq.sv
// Shared power/clock/reset sequencer for all Carfield domains; one FSM
// serves latched on/off requests round-robin, one domain at a time.
module carfield_domain_seq
  import carfield_pkg::*;
#(
  parameter int                    NumDomains  = 6,
  parameter int                    RstCycles   = 4,
  parameter int                    IsoCycles   = 2,
  parameter int                    IdleTimeout = 256,
  parameter logic [NumDomains-1:0] BootOnMask  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumDomains-1:0] req_on_i,
  input  logic [NumDomains-1:0] req_off_i,
  input  logic [NumDomains-1:0] idle_i,
  output logic [NumDomains-1:0] clk_en_o,
  output logic [NumDomains-1:0] rst_o,
  output logic [NumDomains-1:0] iso_o,
  output logic [NumDomains-1:0] active_o,
  output logic [NumDomains-1:0] done_o,
  output logic [NumDomains-1:0] err_timeout_o,
  output logic                  busy_o
);

  localparam int IdxW = (NumDomains > 1) ? $clog2(NumDomains) : 1;
  localparam int CntW = $clog2(max3(RstCycles, IsoCycles, IdleTimeout) + 1);
  localparam logic [CntW-1:0] RstLoad  = CntW'(RstCycles - 1);
  localparam logic [CntW-1:0] IsoLoad  = CntW'(IsoCycles - 1);
  localparam logic [CntW-1:0] IdleLoad = CntW'(IdleTimeout - 1);

  dom_seq_state_e        state_q;
  logic [CntW-1:0]       cnt_q;
  logic [IdxW-1:0]       cur_q;
  dom_ctrl_t             ctrl_q [NumDomains];
  logic [NumDomains-1:0] pend_on_q, pend_off_q, pend_on_d, pend_off_d;
  logic                  arb_valid, grant;
  logic [IdxW-1:0]       gnt_idx;

  carfield_domain_seq_arb #(.NumIn(NumDomains), .IdxW(IdxW)) i_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (pend_on_q | pend_off_q),
    .en_i        (state_q == IDLE),
    .gnt_valid_o (arb_valid),
    .gnt_idx_o   (gnt_idx)
  );

  assign grant  = arb_valid && (state_q == IDLE);
  assign busy_o = (state_q != IDLE);

  for (genvar i = 0; i < NumDomains; i++) begin : g_out
    assign clk_en_o[i] = ctrl_q[i].clk_en;
    assign rst_o[i]    = ctrl_q[i].rst;
    assign iso_o[i]    = ctrl_q[i].iso;
    assign active_o[i] = ctrl_q[i].clk_en & ~ctrl_q[i].rst & ~ctrl_q[i].iso;
  end

  // Grant clears first, so a request arriving for the granted domain is kept.
  always_comb begin
    pend_on_d  = pend_on_q;
    pend_off_d = pend_off_q;
    if (grant) begin
      pend_on_d[gnt_idx]  = 1'b0;
      pend_off_d[gnt_idx] = 1'b0;
    end
    pend_on_d  = (pend_on_d | req_on_i) & ~req_off_i;
    pend_off_d = (pend_off_d & ~(req_on_i & ~req_off_i)) | req_off_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_on_q  <= '0;
      pend_off_q <= '0;
    end else begin
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
    end
  end

  // ISO_REL and CLK_OFF actions land on the edge that returns to IDLE, so
  // the done cycle doubles as the next grant cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cur_q         <= '0;
      done_o        <= '0;
      err_timeout_o <= '0;
      // NOTE: the per-domain control array is reset because its reset value is architectural.
      for (int i = 0; i < NumDomains; i++) ctrl_q[i] <= dom_ctrl_reset(BootOnMask[i]);
    end else begin
      done_o        <= '0;
      err_timeout_o <= '0;
      unique case (state_q)
        IDLE: if (grant) begin
          cur_q <= gnt_idx;
          if (pend_off_q[gnt_idx]) begin
            if (!active_o[gnt_idx]) begin
              done_o[gnt_idx] <= 1'b1;
            end else begin
              ctrl_q[gnt_idx].iso <= 1'b1;
              state_q             <= ISO_SET;
            end
          end else if (active_o[gnt_idx]) begin
            done_o[gnt_idx] <= 1'b1;
          end else begin
            ctrl_q[gnt_idx].clk_en <= 1'b1;
            cnt_q                  <= RstLoad;
            state_q                <= CLK_ON;
          end
        end
        CLK_ON: if (cnt_q == '0) begin
          ctrl_q[cur_q].rst <= 1'b0;
          cnt_q             <= IsoLoad;
          state_q           <= RST_REL;
        end else cnt_q <= cnt_q - 1'b1;
        RST_REL: if (cnt_q == '0) begin
          ctrl_q[cur_q].iso <= 1'b0;
          done_o[cur_q]     <= 1'b1;
          state_q           <= IDLE;
        end else cnt_q <= cnt_q - 1'b1;
        ISO_SET: begin
          cnt_q   <= IdleLoad;
          state_q <= WAIT_IDLE;
        end
        WAIT_IDLE: if (idle_i[cur_q] || cnt_q == '0) begin
          err_timeout_o[cur_q] <= ~idle_i[cur_q];
          ctrl_q[cur_q].rst    <= 1'b1;
          cnt_q                <= RstLoad;
          state_q              <= RST_SET;
        end else cnt_q <= cnt_q - 1'b1;
        RST_SET: if (cnt_q == '0) begin
          ctrl_q[cur_q].clk_en <= 1'b0;
          done_o[cur_q]        <= 1'b1;
          state_q              <= IDLE;
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
